seq_multiplier: RTL and testbench

//   Sequential shift-add multiplier for two single-digit operands (0..9).

---
 rtl/seq_multiplier.sv | 94 +++++++++
 tb/tb_seq_multiplier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Shift-add multiplier for single-digit operands; the product is held
// between operations for the display stage downstream.
module seq_multiplier #(
    parameter int WIDTH       = 4,
    parameter int MAX_OPERAND = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] MAXV   = MAX_OPERAND[WIDTH-1:0];
    localparam logic [CW-1:0]    LAST_C = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;
    logic               r_err;

    logic               w_bad;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_bad      = (a > MAXV) || (b > MAXV);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Result registers load on the edge into DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_err     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        if (w_bad) begin
                            r_state   <= S_DONE;
                            r_product <= '0;
                            r_err     <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST_C) begin
                        r_state   <= S_DONE;
                        r_product <= w_acc_next;
                        r_err     <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign product = r_product;
    assign err     = r_err;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed cases with literal expectations plus
// randomized traffic checked every cycle against an arithmetic model.
module tb_seq_multiplier;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [7:0]   product;
    logic         err;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: cycles left until done (0 = idle), plus the held result.
    int         m_left = 0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_prod = '0;
    logic       m_err  = 1'b0;

    seq_multiplier #(.WIDTH(W), .MAX_OPERAND(9)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_prod <= '0;
            m_err  <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                if (a > 9 || b > 9) begin
                    m_left <= 1;
                    m_prod <= '0;
                    m_err  <= 1'b1;
                end else begin
                    m_left <= W + 1;
                    m_pend <= 8'(a * b);
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_prod <= m_pend;
                m_err  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", 32'(busy), 32'(m_left != 0));
            chk("m_done", 32'(done), 32'(m_left == 1));
            chk("m_product", 32'(product), 32'(m_prod));
            chk("m_err", 32'(err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int ta, input int tb_, input int ep,
                      input int ee, input int el, input logic [7:0] poke);
        bit hit;
        hit   = 1'b0;
        start = 1'b1;
        a     = W'(ta);
        b     = W'(tb_);
        cyc();
        for (int i = 1; i <= 12; i++) begin
            start = (i < 8) ? poke[i] : 1'b0;
            if (start) begin
                a = 4'd6;
                b = 4'd7;
            end else begin
                a = W'($urandom_range(0, 15));
                b = W'($urandom_range(0, 15));
            end
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'(i == el));
            if (i == el) begin
                chk("product", 32'(product), 32'(ep));
                chk("err", 32'(err), 32'(ee));
                hit = 1'b1;
                break;
            end
            cyc();
        end
        if (!hit) chk("timeout", 32'd0, 32'd1);
        cyc();
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cyc();
        cyc();
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk_en = 1'b1;
        rst    = 1'b0;
        cyc();

        op(9, 9, 81, 0, 5, 8'h00);
        op(0, 7, 0, 0, 5, 8'h00);
        op(7, 1, 7, 0, 5, 8'h00);
        op(10, 3, 0, 1, 1, 8'h00);
        op(2, 3, 6, 0, 5, 8'h00);
        op(3, 4, 12, 0, 5, 8'b0010_0100);
        op(6, 7, 42, 0, 5, 8'h00);

        // Abort an 8x8 with reset in cycle 3.
        start = 1'b1;
        a     = 4'd8;
        b     = 4'd8;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_nodone", 32'(done), 32'd0);
        end
        op(5, 5, 25, 0, 5, 8'h00);

        // Random traffic: idle gaps, held start, bad operands, rare resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r     = $urandom_range(0, 99);
            start = (r < 40) || (i % 200 < 20);
            if ($urandom_range(0, 4) == 0) begin
                a = W'($urandom_range(0, 15));
                b = W'($urandom_range(0, 15));
            end else begin
                a = W'($urandom_range(0, 9));
                b = W'($urandom_range(0, 9));
            end
            rst = ($urandom_range(0, 149) == 0);
            cyc();
        end
        start = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
